// File: rtl/riscv_irq_ctrl.sv
// riscv_irq_ctrl: prioritised, vectored interrupt controller driving the core ISR/ISRsel redirect; define RISCV_IRQ_NESTING_EN for one-level preemption
module riscv_irq_ctrl #(
  parameter int                 NUM_IRQ   = 8,
  parameter logic [31:0]        ISR_BASE  = 32'h0000_0100,
  parameter int                 VEC_SHIFT = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        pc,
  input  logic               suspend,
  input  logic               mret,
  input  logic               csr_we,
  input  logic [1:0]         csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic [31:0]        ISR,
  output logic               ISRsel,
  output logic               irq_active,
  output logic [31:0]        epc
);
  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_SERVICE, ST_RETURN} state_t;
  state_t             state_q;
  logic [NUM_IRQ-1:0] pending_q, enable_q, prev_q, pending_d, elig, pend_clr;
  logic               gie_q, any_elig, disp_fire, stk_v, unused_wdata;
  logic [3:0]         id_q, sel_id;
  logic [31:0]        epc_q;
`ifdef RISCV_IRQ_NESTING_EN
  logic               stk_v_q;
  logic [3:0]         stk_id_q;
  logic [31:0]        stk_epc_q;
  assign stk_v = stk_v_q;
`else
  assign stk_v = 1'b0;
`endif
  assign unused_wdata = ^csr_wdata;
  assign elig       = gie_q ? (pending_q & enable_q) : '0;
  assign any_elig   = |elig;
  assign disp_fire  = (state_q == ST_DISPATCH) && !suspend;
  assign irq_active = state_q == ST_SERVICE;
  assign epc        = epc_q;
  // lowest eligible index wins
  always_comb begin
    sel_id = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (elig[i]) sel_id = 4'(i);
  end
  // edge bits hold until dispatched or write-1-cleared, with a new edge winning; level bits track the line
  always_comb begin
    pend_clr  = ((csr_we && csr_addr == 2'd1) ? csr_wdata[NUM_IRQ-1:0] : '0) | (disp_fire ? (NUM_IRQ'(1) << id_q) : '0);
    pending_d = (EDGE_MASK & ((pending_q & ~pend_clr) | (irq_in & ~prev_q))) | (~EDGE_MASK & irq_in);
  end
  // redirect target and strobe; the strobe is suppressed combinationally while the core is stalled
  always_comb begin
    ISR    = state_q == ST_DISPATCH ? ISR_BASE + (32'(id_q) << VEC_SHIFT) : state_q == ST_RETURN ? epc_q : 32'd0;
    ISRsel = (state_q == ST_DISPATCH || state_q == ST_RETURN) && !suspend;
  end
  // register read mux, unused bits zero
  always_comb begin
    csr_rdata = csr_addr == 2'd0 ? 32'(enable_q) :
                csr_addr == 2'd1 ? 32'(pending_q) :
                csr_addr == 2'd2 ? {20'd0, id_q, 5'd0, stk_v, irq_active, gie_q} : epc_q;
  end
  // control FSM plus pending/enable/gie registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      prev_q    <= '0;
      gie_q     <= 1'b0;
      id_q      <= 4'd0;
      epc_q     <= 32'd0;
`ifdef RISCV_IRQ_NESTING_EN
      stk_v_q   <= 1'b0;
      stk_id_q  <= 4'd0;
      stk_epc_q <= 32'd0;
`endif
    end else begin
      pending_q <= pending_d;
      prev_q    <= irq_in;
      if (csr_we && csr_addr == 2'd0) enable_q <= csr_wdata[NUM_IRQ-1:0];
      if (csr_we && csr_addr == 2'd2) gie_q <= csr_wdata[0];
      case (state_q)
        ST_IDLE: if (any_elig) begin
          id_q    <= sel_id;
          state_q <= ST_DISPATCH;
        end
        ST_DISPATCH: if (!suspend) begin
          epc_q   <= pc;
          state_q <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (mret) state_q <= ST_RETURN;
`ifdef RISCV_IRQ_NESTING_EN
          else if (any_elig && sel_id < id_q && !stk_v_q) begin
            stk_v_q   <= 1'b1;
            stk_id_q  <= id_q;
            stk_epc_q <= epc_q;
            id_q      <= sel_id;
            state_q   <= ST_DISPATCH;
          end
`endif
        end
        ST_RETURN: if (!suspend) begin
`ifdef RISCV_IRQ_NESTING_EN
          if (stk_v_q) begin
            stk_v_q <= 1'b0;
            id_q    <= stk_id_q;
            epc_q   <= stk_epc_q;
            state_q <= ST_SERVICE;
          end else state_q <= ST_IDLE;
`else
          state_q <= ST_IDLE;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// tb_riscv_irq_ctrl: scoreboard bench for riscv_irq_ctrl (lines 2,3,5 edge, rest level)
module tb_riscv_irq_ctrl;
  logic        clk = 1'b0, reset = 1'b0, suspend = 1'b0, mret = 1'b0, csr_we = 1'b0;
  logic [7:0]  irq_in = '0;
  logic [31:0] pc = '0, csr_wdata = '0;
  logic [1:0]  csr_addr = '0;
  logic [31:0] csr_rdata, isr, epc;
  logic        isrsel, irq_active, prev_sel = 1'b0;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  riscv_irq_ctrl #(.NUM_IRQ(8), .ISR_BASE(32'h100), .VEC_SHIFT(2), .EDGE_MASK(8'h2C)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .pc(pc), .suspend(suspend), .mret(mret),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .ISR(isr), .ISRsel(isrsel), .irq_active(irq_active), .epc(epc));

  always #5 clk = ~clk;

  // every redirect strobe must match the next expected target
  always @(negedge clk) begin
    if (isrsel === 1'b1) begin
      checks++;
      if (prev_sel) begin errors++; $display("FAIL isrsel_back_to_back isr=%h", isr); end
      if (exp_q.size() == 0) begin errors++; $display("FAIL unexpected_isrsel isr=%h", isr); end
      else begin
        exp_v = exp_q.pop_front();
        if (isr !== exp_v) begin errors++; $display("FAIL redirect_target got=%h exp=%h", isr, exp_v); end
      end
    end
    prev_sel <= (isrsel === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic do_mret(input logic [31:0] ret_pc);
    exp_q.push_back(ret_pc);
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (isrsel !== 1'b0 || isr !== 32'd0) begin errors++; $display("FAIL reset_redirect sel=%b isr=%h exp 0/0", isrsel, isr); end
    checks++; if (epc !== 32'd0 || irq_active !== 1'b0) begin errors++; $display("FAIL reset_state epc=%h act=%b exp 0/0", epc, irq_active); end
    for (int a = 0; a < 4; a++) begin
      csr_addr = 2'(a); #1;
      checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, csr_rdata); end
    end
  endtask

  task automatic test_level();
    csr_write(2'd0, 32'h01);
    csr_write(2'd2, 32'h01);
    irq_in = 8'h01; pc = 32'h40;
    exp_q.push_back(32'h100);
    tick(); tick();
    checks++; if (isrsel !== 1'b1 || isr !== 32'h100) begin errors++; $display("FAIL level_dispatch sel=%b isr=%h exp 1/100", isrsel, isr); end
    tick();
    checks++; if (epc !== 32'h40 || irq_active !== 1'b1) begin errors++; $display("FAIL level_service epc=%h act=%b exp 40/1", epc, irq_active); end
    csr_addr = 2'd2; #1;
    checks++; if (csr_rdata !== 32'h003) begin errors++; $display("FAIL level_ctrl got=%h exp=003", csr_rdata); end
    irq_in = 8'h00;
    do_mret(32'h40);
    checks++; if (isrsel !== 1'b1 || isr !== 32'h40) begin errors++; $display("FAIL level_return sel=%b isr=%h exp 1/40", isrsel, isr); end
    tick(); tick(); tick();
    checks++; if (irq_active !== 1'b0 || isrsel !== 1'b0) begin errors++; $display("FAIL level_idle act=%b sel=%b exp 0/0", irq_active, isrsel); end
  endtask

  task automatic test_priority();
    csr_write(2'd0, 32'hFF);
    irq_in = 8'h28;
    exp_q.push_back(32'h10C);
    tick();
    irq_in = 8'h00;
    tick();
    checks++; if (isr !== 32'h10C) begin errors++; $display("FAIL prio_first isr=%h exp=10C", isr); end
    pc = 32'h200;
    tick();
    csr_addr = 2'd1; #1;
    checks++; if (csr_rdata !== 32'h20) begin errors++; $display("FAIL prio_pending got=%h exp=20", csr_rdata); end
    do_mret(32'h200);
    checks++; if (isrsel !== 1'b1 || isr !== 32'h200) begin errors++; $display("FAIL prio_return sel=%b isr=%h exp 1/200", isrsel, isr); end
    exp_q.push_back(32'h114);
    tick(); tick();
    checks++; if (isrsel !== 1'b1 || isr !== 32'h114) begin errors++; $display("FAIL prio_second sel=%b isr=%h exp 1/114", isrsel, isr); end
    pc = 32'h300;
    tick();
    checks++; if (epc !== 32'h300) begin errors++; $display("FAIL prio_epc got=%h exp=300", epc); end
    do_mret(32'h300);
    tick();
  endtask

  task automatic test_suspend();
    irq_in = 8'h08; suspend = 1'b1;
    exp_q.push_back(32'h10C);
    tick();
    irq_in = 8'h00;
    tick();
    for (int k = 0; k < 3; k++) begin
      pc = 32'h400 + 32'(k); #1;
      checks++; if (isrsel !== 1'b0) begin errors++; $display("FAIL suspend_hold%0d sel=%b exp=0", k, isrsel); end
      tick();
    end
    suspend = 1'b0; pc = 32'h444; #1;
    checks++; if (isrsel !== 1'b1 || isr !== 32'h10C) begin errors++; $display("FAIL suspend_release sel=%b isr=%h exp 1/10C", isrsel, isr); end
    tick();
    checks++; if (epc !== 32'h444 || irq_active !== 1'b1) begin errors++; $display("FAIL suspend_epc epc=%h act=%b exp 444/1", epc, irq_active); end
    do_mret(32'h444);
    tick();
  endtask

  task automatic test_w1c();
    csr_write(2'd2, 32'h0);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick();
    csr_addr = 2'd1; #1;
    checks++; if (csr_rdata !== 32'h04) begin errors++; $display("FAIL w1c_pending got=%h exp=04", csr_rdata); end
    csr_write(2'd1, 32'h04);
    csr_addr = 2'd1; #1;
    checks++; if (csr_rdata !== 32'h00) begin errors++; $display("FAIL w1c_cleared got=%h exp=00", csr_rdata); end
    csr_write(2'd2, 32'h1);
    repeat (4) tick();
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL w1c_no_dispatch act=%b exp=0", irq_active); end
  endtask

  task automatic test_reset_in_service();
    irq_in = 8'h01;
    exp_q.push_back(32'h100);
    tick(); tick();
    pc = 32'h500;
    tick();
    checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL rst_svc_enter act=%b exp=1", irq_active); end
    irq_in = 8'h00; reset = 1'b0;
    tick();
    reset = 1'b1; #1;
    checks++; if (irq_active !== 1'b0 || epc !== 32'd0) begin errors++; $display("FAIL rst_svc_state act=%b epc=%h exp 0/0", irq_active, epc); end
    for (int a = 0; a < 3; a++) begin
      csr_addr = 2'(a); #1;
      checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL rst_svc_reg%0d got=%h exp=0", a, csr_rdata); end
    end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    tick();
    checks++; if (irq_active !== 1'b0 || isrsel !== 1'b0 || isr !== 32'd0) begin errors++; $display("FAIL rst_svc_mret act=%b sel=%b isr=%h exp 0/0/0", irq_active, isrsel, isr); end
  endtask

  task automatic test_nesting();
    csr_write(2'd0, 32'hFF);
    csr_write(2'd2, 32'h1);
    irq_in = 8'h10;
    exp_q.push_back(32'h110);
    tick(); tick();
    checks++; if (isr !== 32'h110) begin errors++; $display("FAIL nest_outer isr=%h exp=110", isr); end
    pc = 32'h600;
    tick();
    irq_in = 8'h12;
`ifdef RISCV_IRQ_NESTING_EN
    exp_q.push_back(32'h104);
    tick(); tick();
    checks++; if (isrsel !== 1'b1 || isr !== 32'h104) begin errors++; $display("FAIL nest_preempt sel=%b isr=%h exp 1/104", isrsel, isr); end
    pc = 32'h650;
    tick();
    csr_addr = 2'd2; #1;
    checks++; if (csr_rdata !== 32'h107 || epc !== 32'h650) begin errors++; $display("FAIL nest_ctrl ctrl=%h epc=%h exp 107/650", csr_rdata, epc); end
    irq_in = 8'h10;
    do_mret(32'h650);
    checks++; if (isrsel !== 1'b1 || isr !== 32'h650) begin errors++; $display("FAIL nest_ret_inner sel=%b isr=%h exp 1/650", isrsel, isr); end
    tick();
    checks++; if (irq_active !== 1'b1 || epc !== 32'h600 || csr_rdata !== 32'h403) begin errors++; $display("FAIL nest_restore act=%b epc=%h ctrl=%h exp 1/600/403", irq_active, epc, csr_rdata); end
    irq_in = 8'h00;
    do_mret(32'h600);
    tick();
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL nest_idle act=%b exp=0", irq_active); end
`else
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (isrsel !== 1'b0 || irq_active !== 1'b1) begin errors++; $display("FAIL no_preempt%0d sel=%b act=%b exp 0/1", k, isrsel, irq_active); end
    end
    csr_addr = 2'd2; #1;
    checks++; if (csr_rdata !== 32'h403) begin errors++; $display("FAIL no_preempt_ctrl got=%h exp=403", csr_rdata); end
    irq_in = 8'h02;
    do_mret(32'h600);
    exp_q.push_back(32'h104);
    tick(); tick();
    checks++; if (isrsel !== 1'b1 || isr !== 32'h104) begin errors++; $display("FAIL waited_dispatch sel=%b isr=%h exp 1/104", isrsel, isr); end
    pc = 32'h700; irq_in = 8'h00;
    tick();
    checks++; if (epc !== 32'h700) begin errors++; $display("FAIL waited_epc got=%h exp=700", epc); end
    do_mret(32'h700);
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_level();
    test_priority();
    test_suspend();
    test_w1c();
    test_reset_in_service();
    test_nesting();
    repeat (3) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
